// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter and read sequencer for a single-port RAM
// Grants one access per cycle, stalls writes behind a fresh read, and returns read data to its port.
module mem_arbiter #(
  parameter int DATA_WIDTH = 12,
  parameter int COUNT      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DATA_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_rerr,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DATA_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_rerr,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [31:0] COUNT_U = 32'(COUNT);

  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic                  rd0_valid_q, rd0_valid_d, rd0_id_q, rd0_id_d, rd0_oor_q, rd0_oor_d;
  logic                  rd1_valid_q, rd1_valid_d, rd1_id_q, rd1_id_d, rd1_oor_q, rd1_oor_d;

  logic                  any_req, winner, win_we, win_oor, blocked, issue;
  logic [DATA_WIDTH-1:0] win_addr, win_wdata;

  always_comb begin
    any_req   = p0_req | p1_req;
    winner    = (p0_req && p1_req) ? ~last_q : p1_req;
    win_we    = winner ? p1_we    : p0_we;
    win_addr  = winner ? p1_addr  : p0_addr;
    win_wdata = winner ? p1_wdata : p0_wdata;
    win_oor   = (32'(win_addr) >= COUNT_U);
    // A write right after a read issue would kill the RAM's read pipeline update,
    // so the whole cycle bubbles and the write is guaranteed to go next cycle.
    blocked   = any_req & win_we & rd0_valid_q;
    issue     = rst_n & any_req & ~blocked;

    p0_gnt    = issue & ~winner;
    p1_gnt    = issue & winner;
    mem_addr  = issue ? win_addr : addr_q;
    mem_we    = issue & win_we & ~win_oor;
    mem_wdata = issue ? win_wdata : '0;
  end

  always_comb begin
    last_d      = issue ? winner : last_q;
    addr_d      = mem_addr;
    rd0_valid_d = issue & ~win_we;
    rd0_id_d    = winner;
    rd0_oor_d   = win_oor;
    rd1_valid_d = rd0_valid_q;
    rd1_id_d    = rd0_id_q;
    rd1_oor_d   = rd0_oor_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      addr_q      <= '0;
      rd0_valid_q <= 1'b0;
      rd0_id_q    <= 1'b0;
      rd0_oor_q   <= 1'b0;
      rd1_valid_q <= 1'b0;
      rd1_id_q    <= 1'b0;
      rd1_oor_q   <= 1'b0;
    end else begin
      last_q      <= last_d;
      addr_q      <= addr_d;
      rd0_valid_q <= rd0_valid_d;
      rd0_id_q    <= rd0_id_d;
      rd0_oor_q   <= rd0_oor_d;
      rd1_valid_q <= rd1_valid_d;
      rd1_id_q    <= rd1_id_d;
      rd1_oor_q   <= rd1_oor_d;
    end
  end

  always_comb begin
    p0_rvalid = rd1_valid_q & ~rd1_id_q;
    p1_rvalid = rd1_valid_q & rd1_id_q;
    p0_rerr   = p0_rvalid & rd1_oor_q;
    p1_rerr   = p1_rvalid & rd1_oor_q;
    p0_rdata  = rd1_oor_q ? '0 : mem_rdata;
    p1_rdata  = rd1_oor_q ? '0 : mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a two-cycle-read RAM stub
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [11:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_rvalid, p0_rerr, p1_gnt, p1_rvalid, p1_rerr;
  logic [11:0] p0_rdata, p1_rdata;
  logic [11:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [11:0] ram [0:63];
  logic [11:0] ram_addr_q, ram_dout_q;
  logic        fill;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(12), .COUNT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_rerr(p0_rerr),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_rerr(p1_rerr),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM stub: registered address, output register skipped on write cycles
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 64; i++) ram[i] <= 12'h400 + 12'(i);
    end else begin
      ram_addr_q <= mem_addr;
      if (mem_we && mem_addr < 12'd64) ram[mem_addr[5:0]] <= mem_wdata;
      if (!mem_we) ram_dout_q <= (ram_addr_q < 12'd64) ? ram[ram_addr_q[5:0]] : 12'h0;
    end
  end
  assign mem_rdata = ram_dout_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [11:0] a0, input logic [11:0] d0,
                       input logic r1, input logic w1, input logic [11:0] a1, input logic [11:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    fill  = 1'b1;
    drive(1'b1, 1'b1, 12'd5, 12'hABC, 1'b0, 1'b0, 12'd0, 12'd0);
    step;
    fill = 1'b0;
    @(negedge clk);
    chk("rst_p0_gnt", 32'(p0_gnt), 0);
    chk("rst_p1_gnt", 32'(p1_gnt), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_p0_rvalid", 32'(p0_rvalid), 0);

    // write then read back through port 0
    step; rst_n = 1'b1;
    @(negedge clk);
    chk("wr5_p0_gnt", 32'(p0_gnt), 1);
    chk("wr5_p1_gnt", 32'(p1_gnt), 0);
    chk("wr5_mem_we", 32'(mem_we), 1);
    chk("wr5_mem_addr", 32'(mem_addr), 5);
    chk("wr5_mem_wdata", 32'(mem_wdata), 32'hABC);
    step; drive(1'b1, 1'b0, 12'd5, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    chk("rd5_p0_gnt", 32'(p0_gnt), 1);
    chk("rd5_mem_we", 32'(mem_we), 0);
    chk("rd5_mem_addr", 32'(mem_addr), 5);
    step; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    chk("idle_p0_gnt", 32'(p0_gnt), 0);
    chk("idle_mem_addr_hold", 32'(mem_addr), 5);
    chk("rd5_early_rvalid", 32'(p0_rvalid), 0);
    step;
    @(negedge clk);
    chk("rd5_p0_rvalid", 32'(p0_rvalid), 1);
    chk("rd5_p0_rdata", 32'(p0_rdata), 32'hABC);
    chk("rd5_p0_rerr", 32'(p0_rerr), 0);
    chk("rd5_p1_rvalid", 32'(p1_rvalid), 0);
    step;
    @(negedge clk);
    chk("rd5_rvalid_pulse", 32'(p0_rvalid), 0);

    // out-of-range write and read on port 1
    step; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 12'd64, 12'h123);
    @(negedge clk);
    chk("oorw_p1_gnt", 32'(p1_gnt), 1);
    chk("oorw_p0_gnt", 32'(p0_gnt), 0);
    chk("oorw_mem_we", 32'(mem_we), 0);
    step; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b0, 12'd64, 12'd0);
    @(negedge clk);
    chk("oorr_p1_gnt", 32'(p1_gnt), 1);
    step; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    chk("oorr_early_rvalid", 32'(p1_rvalid), 0);
    step;
    @(negedge clk);
    chk("oorr_p1_rvalid", 32'(p1_rvalid), 1);
    chk("oorr_p1_rerr", 32'(p1_rerr), 1);
    chk("oorr_p1_rdata", 32'(p1_rdata), 0);
    chk("oorr_p0_rvalid", 32'(p0_rvalid), 0);
    chk("oorw_ram0_unchanged", 32'(ram[0]), 32'h400);

    // continuous tie: alternate grants starting with port 0
    for (int i = 0; i < 8; i++) begin
      step;
      if (i < 6) drive(1'b1, 1'b0, 12'd1, 12'd0, 1'b1, 1'b0, 12'd2, 12'd0);
      else       drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
      @(negedge clk);
      chk($sformatf("rr%0d_p0_gnt", i), 32'(p0_gnt), 32'(i < 6 && i % 2 == 0));
      chk($sformatf("rr%0d_p1_gnt", i), 32'(p1_gnt), 32'(i < 6 && i % 2 == 1));
      chk($sformatf("rr%0d_p0_rvalid", i), 32'(p0_rvalid), 32'(i >= 2 && i % 2 == 0));
      chk($sformatf("rr%0d_p1_rvalid", i), 32'(p1_rvalid), 32'(i >= 2 && i % 2 == 1));
      if (i >= 2 && i % 2 == 0) chk($sformatf("rr%0d_p0_rdata", i), 32'(p0_rdata), 32'h401);
      if (i >= 2 && i % 2 == 1) chk($sformatf("rr%0d_p1_rdata", i), 32'(p1_rdata), 32'h402);
    end

    // write behind a read gets a bubble, then issues as the read returns
    step; drive(1'b1, 1'b0, 12'd3, 12'd0, 1'b1, 1'b1, 12'd3, 12'h7EE);
    @(negedge clk);
    chk("haz_t0_p0_gnt", 32'(p0_gnt), 1);
    chk("haz_t0_p1_gnt", 32'(p1_gnt), 0);
    step; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 12'd3, 12'h7EE);
    @(negedge clk);
    chk("haz_t1_p0_gnt", 32'(p0_gnt), 0);
    chk("haz_t1_p1_gnt", 32'(p1_gnt), 0);
    chk("haz_t1_mem_we", 32'(mem_we), 0);
    step;
    @(negedge clk);
    chk("haz_t2_p1_gnt", 32'(p1_gnt), 1);
    chk("haz_t2_mem_we", 32'(mem_we), 1);
    chk("haz_t2_mem_addr", 32'(mem_addr), 3);
    chk("haz_t2_p0_rvalid", 32'(p0_rvalid), 1);
    chk("haz_t2_p0_rdata", 32'(p0_rdata), 32'h403);
    step; drive(1'b1, 1'b0, 12'd3, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    chk("haz_rb_p0_gnt", 32'(p0_gnt), 1);
    step; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    step;
    @(negedge clk);
    chk("haz_rb_p0_rvalid", 32'(p0_rvalid), 1);
    chk("haz_rb_p0_rdata", 32'(p0_rdata), 32'h7EE);

    // reset right after a read issue discards it and restores last pointer
    step; drive(1'b1, 1'b0, 12'd1, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    chk("mrst_p0_gnt", 32'(p0_gnt), 1);
    step; rst_n = 1'b0; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);
    @(negedge clk);
    chk("mrst_in_p0_rvalid", 32'(p0_rvalid), 0);
    chk("mrst_in_mem_addr", 32'(mem_addr), 0);
    step; rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_post0_p0_rvalid", 32'(p0_rvalid), 0);
    step;
    @(negedge clk);
    chk("mrst_post1_p0_rvalid", 32'(p0_rvalid), 0);
    chk("mrst_post1_p1_rvalid", 32'(p1_rvalid), 0);
    step; drive(1'b1, 1'b0, 12'd1, 12'd0, 1'b1, 1'b0, 12'd2, 12'd0);
    @(negedge clk);
    chk("mrst_tie_p0_gnt", 32'(p0_gnt), 1);
    chk("mrst_tie_p1_gnt", 32'(p1_gnt), 0);
    step;
    @(negedge clk);
    chk("mrst_tie2_p1_gnt", 32'(p1_gnt), 1);
    step; drive(1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 1'b0, 12'd0, 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of the single-port `memory` block (registered address, two-cycle read, write-blocks-read behaviour). It shares the RAM between the instruction-fetch requester (port 0) and the load/store requester (port 1). It grants one access per cycle with round-robin fairness and enforces the RAM's write-after-read hazard. It routes read data back to the issuing port with a valid strobe.

## Interface
- `DATA_WIDTH`, default 12: address and data width, shared by both ports and the RAM.
- `COUNT`, default 64: number of RAM words; addresses `>= COUNT` are out of range.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p0_req`, `p1_req`  in  1  access request; held high with command stable until granted.
- `p0_we`, `p1_we`  in  1  1 = write, 0 = read.
- `p0_addr`, `p1_addr`  in  DATA_WIDTH  word address.
- `p0_wdata`, `p1_wdata`  in  DATA_WIDTH  write data.
- `p0_gnt`, `p1_gnt`  out  1  combinational grant; the command is issued to the RAM this cycle.
- `p0_rvalid`, `p1_rvalid`  out  1  read data valid, one-cycle pulse.
- `p0_rdata`, `p1_rdata`  out  DATA_WIDTH  read data, meaningful only while the matching `rvalid` is high.
- `p0_rerr`, `p1_rerr`  out  1  pulses with `rvalid` when the read address was out of range.
- `mem_addr`  out  DATA_WIDTH  to RAM `addr`.
- `mem_we`  out  1  to RAM `write_enable`.
- `mem_wdata`  out  DATA_WIDTH  to RAM `data_in`.
- `mem_rdata`  in  DATA_WIDTH  from RAM `data_out`.

## Operation
- At most one command is issued per cycle. A grant means the RAM sees `mem_addr`/`mem_we`/`mem_wdata` from the granted port in that same cycle.
- Arbitration:
  - Single requester: that requester is the winner.
  - Both requesting: the port not granted most recently wins.
  - `last` pointer updates only on an actual grant; reset value = port 1, so port 0 wins the first tie.
- Write hazard:
  - The RAM drops its read pipeline update during a write.
  - A write may not be issued in the cycle immediately after a read issue (`rd_pipe[0].valid`).
  - If the winner is such a blocked write, nothing is issued that cycle. The other port is not granted (bubble), and `last` is unchanged. This guarantees the write issues next cycle and prevents starvation.
- Read return pipeline: two stages, each {valid, port id, oor flag}. Stage 0 loads on a read issue; stage 1 loads from stage 0 every cycle. Stage 1 valid drives `pN_rvalid` for its id.
- `pN_rdata` = `mem_rdata` when not out of range, 0 when out of range. Both ports may see `mem_rdata` on `rdata`; only `rvalid` qualifies it.
- Out of range (`addr >= COUNT`):
  - Writes are granted but `mem_we` is forced 0, so the data is dropped.
  - Reads are granted and return 0 with `rerr` = 1.
- Idle cycle: `mem_we` = 0 and `mem_addr` holds the last issued address. An idle cycle is therefore a harmless RAM read.

## Timing
- Grant latency: 0 cycles. `gnt` is asserted in the cycle of issue, and the requester may change its command on the next cycle.
- Read issued in cycle T: `rvalid` and `rdata` are valid in cycle T+2. Reads may issue back-to-back, one per cycle, for full throughput.
- Write issued in cycle T: RAM is updated at the end of T. A read of the same address issued at T+1 returns the new data.
- Read at T followed by a write request at T+1: the write is stalled to T+2. Its read data still returns at T+2, and the write issues in that same cycle.
- While `rst_n` = 0:
  - all `gnt`, `rvalid`, `rerr` and `mem_we` are 0;
  - `mem_addr` and `mem_wdata` are 0;
  - the pipeline valids are cleared and `last` = 1.
- Reset asserted mid-read: in-flight reads are discarded with no `rvalid` after release. The first grant is possible in the first cycle with `rst_n` = 1.

## Test plan
- Reset then p0 write addr 5 data 0xABC, then p0 read addr 5 → `p0_gnt` same cycle; `p0_rvalid` 2 cycles after the read grant with `p0_rdata` = 0xABC; `p1_rvalid` stays 0.
- Both ports request reads continuously (p0 addr 1, p1 addr 2) → grants alternate 0,1,0,1 starting with port 0; `rvalid` alternates with 2-cycle lag carrying the respective words.
- p0 read at T with p1 write pending → p1 write blocked at T+1 (no grant to either port), granted at T+2; `p0_rvalid` at T+2 has correct data unaffected by the write.
- p1 write addr 64 data 0x123, then p1 read addr 64 → `mem_we` stays 0, RAM unchanged; read returns `p1_rdata` = 0, `p1_rerr` = 1.
- Read granted, `rst_n` pulsed low the next cycle → no `rvalid` after release; `last` is reset, so a subsequent tie grants port 0.
